tx_lane_ctrl: RTL and testbench
===============================

TX_LANE_CTRL -- requirements
Module: tx_lane_ctrl

Interface
REQ-001 SHALL have parameter T_LPX, default 2: LP-01 request duration in clk cycles.
REQ-002 SHALL have parameter T_HS_PREPARE, default 3: LP-00 prepare duration in cycles.
REQ-003 SHALL have parameter T_HS_ZERO, default 5: HS-zero duration in cycles.
REQ-004 SHALL have parameter T_HS_TRAIL, default 4: HS-trail duration in cycles.
REQ-005 SHALL have parameter T_HS_EXIT, default 3: LP-11 exit duration in cycles.
REQ-006 SHALL have port clk  input  1  single byte clock; all logic on its rising edge.
REQ-007 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-008 SHALL have port tx_request_hs  input  1  HS burst request.
REQ-009 SHALL have port tx_data  input  8  HS payload byte, LSB transmitted first.
REQ-010 SHALL have port tx_ready_hs  output  1  byte on tx_data accepted this cycle.
REQ-011 SHALL have port hs_en  output  1  HS driver enable.
REQ-012 SHALL have port hs_byte  output  8  registered byte to serializer.
REQ-013 SHALL have port lp_dp  output  1  LP Dp line level.
REQ-014 SHALL have port lp_dn  output  1  LP Dn line level.
REQ-015 SHALL have port stop_state  output  1  lane in LP-11 stop state.

Function
REQ-016 SHALL implement states STOP, HS_RQST, HS_PREP, HS_ZERO, HS_SYNC, HS_DATA, HS_TRAIL, HS_EXIT.
REQ-017 STOP: lp=11, hs_en=0, stop_state=1; tx_request_hs=1 -> HS_RQST next cycle; minimum stay 1 cycle.
REQ-018 HS_RQST: lp=01 for T_LPX cycles -> HS_PREP; HS_PREP: lp=00 for T_HS_PREPARE cycles -> HS_ZERO.
REQ-019 HS_ZERO: hs_en=1, hs_byte=0x00 for T_HS_ZERO cycles -> HS_SYNC; HS_SYNC: hs_byte=0xB8 for 1 cycle.
REQ-020 HS_SYNC -> HS_DATA if tx_request_hs=1, else HS_TRAIL.
REQ-021 HS_DATA: tx_ready_hs=1 combinationally; hs_byte=tx_data registered (1-cycle latency); request low -> HS_TRAIL next cycle, that cycle's byte not accepted.
REQ-022 HS_TRAIL: hs_byte={8{~b}}, b = bit 7 of last byte sent (data or sync), for T_HS_TRAIL cycles -> HS_EXIT.
REQ-023 HS_EXIT: hs_en=0, lp=11, stop_state=0 for T_HS_EXIT cycles -> STOP.
REQ-024 Request deassertion during HS_RQST/HS_PREP/HS_ZERO SHALL be ignored; sequence completes through HS_SYNC.
REQ-025 Each timed state SHALL last max(param,1) cycles; one shared down-counter, reloaded on state entry.
REQ-026 lp_dp/lp_dn SHALL be 0 while hs_en=1; tx_ready_hs=0 outside HS_DATA.

Reset
REQ-027 rst low SHALL immediately force STOP, lp=11, hs_en=0, hs_byte=0x00, tx_ready_hs=0, stop_state=1, counter=0, from any state including mid-HS_DATA.
REQ-028 After rst release, first HS_RQST SHALL occur no earlier than the second rising edge.

Configuration
REQ-029 With TX_LANE_REQ_SYNC_EN defined, tx_request_hs SHALL pass through an internal 2-flop synchronizer (reset 0), adding 2 cycles to request entry and exit; without it, tx_request_hs is sampled directly.

Structure
REQ-030 Shared package dphy_pkg SHALL hold state encoding, SYNC_BYTE=0xB8, LP codes LP11/LP01/LP00.
REQ-031 Sub-module tx_lane_timer (loadable down-counter, done flag) SHALL implement the duration counting.

Verification
REQ-032 Assert rst low mid-run -> lp=11, hs_en=0, stop_state=1, tx_ready_hs=0 same cycle.
REQ-033 Default params, burst 0x11,0x22,0x33 -> LP-01 x2, LP-00 x3, 0x00 x5, 0xB8, 0x11,0x22,0x33, 0xFF x4, LP-11 x3, stop_state=1.
REQ-034 Burst ending 0x80 -> trail 0x00 x4.
REQ-035 Request dropped during HS_ZERO -> 0xB8 then trail 0x00 x4, tx_ready_hs never 1.
REQ-036 Request held high through HS_EXIT -> exactly 1 STOP cycle, then new HS_RQST.
REQ-037 With TX_LANE_REQ_SYNC_EN, scenario REQ-033 -> HS_RQST entry 2 cycles later, 3 data bytes unchanged.

Source files
------------

// File: rtl/dphy_pkg.sv
// Shared D-PHY lane definitions: FSM state encoding, sync byte, LP line codes
// and the timer reload helper used by the TX lane controller.
package dphy_pkg;

    localparam int CNT_W = 8;

    localparam logic [2:0] ST_STOP     = 3'd0;
    localparam logic [2:0] ST_HS_RQST  = 3'd1;
    localparam logic [2:0] ST_HS_PREP  = 3'd2;
    localparam logic [2:0] ST_HS_ZERO  = 3'd3;
    localparam logic [2:0] ST_HS_SYNC  = 3'd4;
    localparam logic [2:0] ST_HS_DATA  = 3'd5;
    localparam logic [2:0] ST_HS_TRAIL = 3'd6;
    localparam logic [2:0] ST_HS_EXIT  = 3'd7;

    localparam logic [7:0] SYNC_BYTE = 8'hB8;

    // LP codes are {dp, dn}
    localparam logic [1:0] LP11 = 2'b11;
    localparam logic [1:0] LP01 = 2'b01;
    localparam logic [1:0] LP00 = 2'b00;

    typedef struct packed {
        logic [1:0] lp;
        logic       hs;
        logic       stop;
        logic [7:0] data;
    } line_t;

    // Reload value so a timed state lasts max(p,1) cycles.
    function automatic logic [CNT_W-1:0] dur_load(input int p);
        return (p <= 1) ? '0 : CNT_W'(p - 1);
    endfunction

endpackage

// File: rtl/tx_lane_timer.sv
// Loadable down-counter shared by all timed lane states; done while the count is zero.
module tx_lane_timer
    import dphy_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             done
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/tx_lane_ctrl.sv
// D-PHY TX lane sequencer: LP-11 -> LP-01 -> LP-00 -> HS burst -> trail -> LP-11.
// Define TX_LANE_REQ_SYNC_EN to pass tx_request_hs through a 2-flop synchronizer.
//
// state       | meaning
// ST_STOP     | LP-11 stop state, waiting for a request
// ST_HS_RQST  | LP-01 HS request, T_LPX cycles
// ST_HS_PREP  | LP-00 prepare, T_HS_PREPARE cycles
// ST_HS_ZERO  | HS driving 0x00, T_HS_ZERO cycles
// ST_HS_SYNC  | HS sync byte 0xB8, one cycle
// ST_HS_DATA  | HS payload, accepting tx_data while requested
// ST_HS_TRAIL | HS trail of inverted last bit, T_HS_TRAIL cycles
// ST_HS_EXIT  | LP-11 before stop, T_HS_EXIT cycles
module tx_lane_ctrl
    import dphy_pkg::*;
#(
    parameter int T_LPX        = 2,
    parameter int T_HS_PREPARE = 3,
    parameter int T_HS_ZERO    = 5,
    parameter int T_HS_TRAIL   = 4,
    parameter int T_HS_EXIT    = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_request_hs,
    input  logic [7:0] tx_data,
    output logic       tx_ready_hs,
    output logic       hs_en,
    output logic [7:0] hs_byte,
    output logic       lp_dp,
    output logic       lp_dn,
    output logic       stop_state
);

    localparam logic [CNT_W-1:0] LD_LPX        = dur_load(T_LPX);
    localparam logic [CNT_W-1:0] LD_PREP       = dur_load(T_HS_PREPARE);
    localparam logic [CNT_W-1:0] LD_ZERO       = dur_load(T_HS_ZERO);
    localparam logic [CNT_W-1:0] LD_TRAIL      = dur_load(T_HS_TRAIL);
    localparam logic [CNT_W-1:0] LD_TRAIL_DATA = dur_load(T_HS_TRAIL - 1);
    localparam logic [CNT_W-1:0] LD_EXIT       = dur_load(T_HS_EXIT);
    localparam logic             TRAIL_SKIP    = (T_HS_TRAIL <= 1);

    logic             req;
    logic [2:0]       state, state_nxt;
    logic             load, done, armed, last_b7;
    logic [CNT_W-1:0] load_val;
    logic [7:0]       trail;
    line_t            slot, line_q;

`ifdef TX_LANE_REQ_SYNC_EN
    logic [1:0] req_sync;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            req_sync <= 2'b00;
        else
            req_sync <= {req_sync[0], tx_request_hs};
    end
    assign req = req_sync[1];
`else
    assign req = tx_request_hs;
`endif

    tx_lane_timer u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (load_val),
        .done     (done)
    );

    assign trail = {8{~last_b7}};

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        load_val  = '0;
        case (state)
            ST_STOP:
                if (req && armed) begin
                    state_nxt = ST_HS_RQST; load = 1'b1; load_val = LD_LPX;
                end
            ST_HS_RQST:
                if (done) begin
                    state_nxt = ST_HS_PREP; load = 1'b1; load_val = LD_PREP;
                end
            ST_HS_PREP:
                if (done) begin
                    state_nxt = ST_HS_ZERO; load = 1'b1; load_val = LD_ZERO;
                end
            ST_HS_ZERO:
                if (done) state_nxt = ST_HS_SYNC;
            ST_HS_SYNC:
                if (req) begin
                    state_nxt = ST_HS_DATA;
                end else begin
                    state_nxt = ST_HS_TRAIL; load = 1'b1; load_val = LD_TRAIL;
                end
            // The DATA cycle that sees the request drop already drives the first trail byte.
            ST_HS_DATA:
                if (!req) begin
                    load = 1'b1;
                    if (TRAIL_SKIP) begin
                        state_nxt = ST_HS_EXIT; load_val = LD_EXIT;
                    end else begin
                        state_nxt = ST_HS_TRAIL; load_val = LD_TRAIL_DATA;
                    end
                end
            ST_HS_TRAIL:
                if (done) begin
                    state_nxt = ST_HS_EXIT; load = 1'b1; load_val = LD_EXIT;
                end
            ST_HS_EXIT:
                if (done) state_nxt = ST_STOP;
            default:
                state_nxt = ST_STOP;
        endcase
    end

    always_comb begin
        slot.lp   = LP11;
        slot.hs   = 1'b0;
        slot.stop = 1'b0;
        slot.data = 8'h00;
        case (state)
            ST_STOP:     slot.stop = 1'b1;
            ST_HS_RQST:  slot.lp   = LP01;
            ST_HS_PREP:  slot.lp   = LP00;
            ST_HS_ZERO:  begin slot.lp = LP00; slot.hs = 1'b1; end
            ST_HS_SYNC:  begin slot.lp = LP00; slot.hs = 1'b1; slot.data = SYNC_BYTE; end
            ST_HS_DATA:  begin slot.lp = LP00; slot.hs = 1'b1; slot.data = req ? tx_data : trail; end
            ST_HS_TRAIL: begin slot.lp = LP00; slot.hs = 1'b1; slot.data = trail; end
            default:     slot.lp   = LP11;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_STOP;
            armed       <= 1'b0;
            last_b7     <= 1'b0;
            line_q.lp   <= LP11;
            line_q.hs   <= 1'b0;
            line_q.stop <= 1'b1;
            line_q.data <= 8'h00;
        end else begin
            state  <= state_nxt;
            armed  <= 1'b1;
            line_q <= slot;
            if (state == ST_HS_SYNC)
                last_b7 <= SYNC_BYTE[7];
            else if (state == ST_HS_DATA && req)
                last_b7 <= tx_data[7];
        end
    end

    assign tx_ready_hs      = (state == ST_HS_DATA) && req;
    assign {lp_dp, lp_dn}   = line_q.lp;
    assign hs_en            = line_q.hs;
    assign stop_state       = line_q.stop;
    assign hs_byte          = line_q.data;

endmodule

// File: tb/tb_tx_lane_ctrl.sv
// Randomized bench for tx_lane_ctrl: observed lane lines are compared slot by slot
// against a burst sequence built from the lane timing rules.
module tb_tx_lane_ctrl;

    localparam int P_LPX   = 2;
    localparam int P_PREP  = 3;
    localparam int P_ZERO  = 5;
    localparam int P_TRAIL = 4;
    localparam int P_EXIT  = 3;
`ifdef TX_LANE_REQ_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tx_request_hs = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_ready_hs, hs_en, lp_dp, lp_dn, stop_state;
    logic [7:0] hs_byte;

    int          n_chk = 0;
    int          n_err = 0;
    int          rdy_cnt;
    logic [11:0] rec [0:127];
    logic [7:0]  bytes [0:63];

    tx_lane_ctrl #(
        .T_LPX        (P_LPX),
        .T_HS_PREPARE (P_PREP),
        .T_HS_ZERO    (P_ZERO),
        .T_HS_TRAIL   (P_TRAIL),
        .T_HS_EXIT    (P_EXIT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .tx_request_hs (tx_request_hs),
        .tx_data       (tx_data),
        .tx_ready_hs   (tx_ready_hs),
        .hs_en         (hs_en),
        .hs_byte       (hs_byte),
        .lp_dp         (lp_dp),
        .lp_dn         (lp_dn),
        .stop_state    (stop_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int mx1(input int p);
        return (p < 1) ? 1 : p;
    endfunction

    // Line slot packing: {dp, dn, hs_en, stop_state, byte (0 when hs_en low)}
    task automatic run_burst(input int n, input bit drop_zero, input bit reraise,
                             input int exp_f, input int ncyc);
        int          idx = 0;
        int          drop_cyc = -10;
        int          f = -1;
        int          nd;
        bit          dropped = 1'b0;
        logic        rdy;
        logic [7:0]  last, tr;
        logic [11:0] exp_q [$];
        rdy_cnt       = 0;
        tx_data       = bytes[0];
        tx_request_hs = 1'b1;
        for (int cyc = 0; cyc < ncyc; cyc++) begin
            @(negedge clk);
            rec[cyc] = {lp_dp, lp_dn, hs_en, stop_state, hs_en ? hs_byte : 8'h00};
            rdy = tx_ready_hs;
            if (rdy) rdy_cnt++;
            @(posedge clk);
            #1;
            if (rdy && idx < 63) begin
                idx++;
                tx_data = bytes[idx];
            end
            if (drop_zero) begin
                if (cyc == 6 + LAT) tx_request_hs = 1'b0;
            end else if (!dropped) begin
                if (idx + LAT >= n) begin
                    tx_request_hs = 1'b0;
                    dropped = 1'b1;
                    drop_cyc = cyc;
                end
            end else if (reraise && cyc == drop_cyc + 1) begin
                tx_request_hs = 1'b1;
            end
        end

        for (int i = 0; i < ncyc; i++)
            if (f < 0 && rec[i][11:10] == 2'b01) f = i;
        check("rqst_lat", f, exp_f);

        nd   = drop_zero ? 0 : n;
        last = (nd > 0) ? bytes[nd-1] : 8'hB8;
        tr   = last[7] ? 8'h00 : 8'hFF;
        repeat (mx1(P_LPX))   exp_q.push_back({2'b01, 1'b0, 1'b0, 8'h00});
        repeat (mx1(P_PREP))  exp_q.push_back({2'b00, 1'b0, 1'b0, 8'h00});
        repeat (mx1(P_ZERO))  exp_q.push_back({2'b00, 1'b1, 1'b0, 8'h00});
        exp_q.push_back({2'b00, 1'b1, 1'b0, 8'hB8});
        for (int k = 0; k < nd; k++) exp_q.push_back({2'b00, 1'b1, 1'b0, bytes[k]});
        repeat (mx1(P_TRAIL)) exp_q.push_back({2'b00, 1'b1, 1'b0, tr});
        repeat (mx1(P_EXIT))  exp_q.push_back({2'b11, 1'b0, 1'b0, 8'h00});
        if (reraise) begin
            exp_q.push_back({2'b11, 1'b0, 1'b1, 8'h00});
            exp_q.push_back({2'b01, 1'b0, 1'b0, 8'h00});
        end else begin
            repeat (3) exp_q.push_back({2'b11, 1'b0, 1'b1, 8'h00});
        end

        if (f >= 0) begin
            for (int i = 0; i < exp_q.size(); i++) begin
                if (f + i < ncyc)
                    check($sformatf("slot%0d", i), rec[f+i], exp_q[i]);
                else
                    check("slot_missing", i, exp_q.size());
            end
        end
        if (!reraise) check("rdy_cnt", rdy_cnt, nd);
    endtask

    initial begin
        int n;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_lines", {lp_dp, lp_dn, hs_en, stop_state, hs_byte}, 12'hD00);
        check("rst_rdy", tx_ready_hs, 1'b0);

        // request already high when reset releases
        for (int i = 0; i < 64; i++) bytes[i] = 8'($urandom);
        tx_request_hs = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        run_burst(3, 1'b0, 1'b0, (LAT + 1 > 2) ? LAT + 1 : 2, 50);

        bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33;
        @(posedge clk); #1;
        run_burst(3, 1'b0, 1'b0, 2 + LAT, 50);

        n = $urandom_range(3, 6);
        for (int i = 0; i < 64; i++) bytes[i] = 8'($urandom);
        bytes[n-1] = 8'h80;
        @(posedge clk); #1;
        run_burst(n, 1'b0, 1'b0, 2 + LAT, 50);

        @(posedge clk); #1;
        run_burst(0, 1'b1, 1'b0, 2 + LAT, 50);

        repeat (3) begin
            n = $urandom_range(3, 6);
            for (int i = 0; i < 64; i++) bytes[i] = 8'($urandom);
            @(posedge clk); #1;
            run_burst(n, 1'b0, 1'b0, 2 + LAT, 50);
        end

        // request held through exit, then reset in the middle of the second burst
        n = $urandom_range(3, 6);
        for (int i = 0; i < 64; i++) bytes[i] = 8'($urandom);
        @(posedge clk); #1;
        run_burst(n, 1'b0, 1'b1, 2 + LAT, 60);
        @(negedge clk);
        check("pre_rst_rdy", tx_ready_hs, 1'b1);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_lines", {lp_dp, lp_dn, hs_en, stop_state, hs_byte}, 12'hD00);
        check("mid_rst_rdy", tx_ready_hs, 1'b0);
        tx_request_hs = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("post_rst_idle", {lp_dp, lp_dn, hs_en, stop_state}, 4'hD);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
